// File: rtl/dp_ram_pkg.sv
// Shared definitions for the single-clock dual-port RAM and its reader/writer engines.
// Holds the RAM read latency, default widths and the reader's state encoding.
package dp_ram_pkg;

    localparam int unsigned RamReadLatency = 1;
    localparam int unsigned DefAddrWidth   = 8;
    localparam int unsigned DefDataWidth   = 8;
    localparam int unsigned SkidDepth      = 2;

    typedef logic [1:0] rd_state_t;

    localparam rd_state_t StIdle  = 2'd0;
    localparam rd_state_t StRun   = 2'd1;
    localparam rd_state_t StDrain = 2'd2;

    // A new read may issue only if every word already owed to the buffer still fits
    // once this cycle's pop has been taken out.
    function automatic logic issue_allowed(input logic [1:0] count,
                                           input logic       pop,
                                           input logic       inflight);
        logic [2:0] load;
        load = 3'(count) - 3'(pop) + 3'(inflight);
        return load < 3'(SkidDepth);
    endfunction

endpackage

// File: rtl/dp_ram_stream_reader_if.sv
// Valid/ready stream carrying RAM words with a last-beat flag.
interface dp_ram_stream_reader_if #(
    parameter int unsigned DATA_WIDTH = dp_ram_pkg::DefDataWidth
);

    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready buffer. The writer must consult count_o before pushing;
// a push into a full buffer is not back-pressured.
module stream_skid_buf
    import dp_ram_pkg::*;
#(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [SkidDepth];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             push;
    logic             pop;

    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign push        = in_valid_i & (count_q != 2'(SkidDepth));
    assign pop         = out_valid_o & out_ready_i;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SkidDepth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dp_ram_stream_reader.sv
// Read-side engine for the dual-port RAM: turns a {base, count} command into a
// valid/ready word stream with a last-beat flag, tolerating consumer backpressure.
module dp_ram_stream_reader
    import dp_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [ADDR_WIDTH:0]   length_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_do_i,
    dp_ram_stream_reader_if.master m_if
);

    localparam logic [ADDR_WIDTH:0] CntOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

    rd_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [ADDR_WIDTH:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_WIDTH:0]   beat_cnt_q, beat_cnt_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic                  done_q, done_d;

    logic                  busy;
    logic                  issue;
    logic                  pop;
    logic                  final_hs;
    logic                  flush;
    logic                  buf_valid;
    logic [DATA_WIDTH:0]   buf_out;
    logic [1:0]            buf_count;

    assign busy     = (state_q != StIdle);
    assign pop      = buf_valid & m_if.m_ready;
    assign final_hs = pop & (beat_cnt_q == CntOne);
    // A final handshake racing an abort wins: the transfer counts as complete.
    assign flush    = abort_i & busy & ~final_hs;
    assign issue    = (state_q == StRun) & ~abort_i & issue_allowed(buf_count, pop, inflight_q);

    always_comb begin
        state_d         = state_q;
        ram_addr_d      = ram_addr_q;
        issue_cnt_d     = issue_cnt_q;
        beat_cnt_d      = beat_cnt_q;
        inflight_d      = issue;
        inflight_last_d = issue & (issue_cnt_q == CntOne);
        done_d          = 1'b0;

        if (issue) begin
            ram_addr_d  = ram_addr_q + 1'b1;
            issue_cnt_d = issue_cnt_q - CntOne;
        end
        if (pop) begin
            beat_cnt_d = beat_cnt_q - CntOne;
        end

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (length_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = StRun;
                        ram_addr_d  = start_addr_i;
                        issue_cnt_d = length_i;
                        beat_cnt_d  = length_i;
                    end
                end
            end
            StRun: begin
                if (issue && (issue_cnt_q == CntOne)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (final_hs) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            state_d         = StIdle;
            inflight_d      = 1'b0;
            inflight_last_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= StIdle;
            ram_addr_q      <= '0;
            issue_cnt_q     <= '0;
            beat_cnt_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            ram_addr_q      <= ram_addr_d;
            issue_cnt_q     <= issue_cnt_d;
            beat_cnt_q      <= beat_cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    stream_skid_buf #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush),
        .in_valid_i  (inflight_q),
        .in_data_i   ({inflight_last_q, ram_do_i}),
        .out_valid_o (buf_valid),
        .out_ready_i (m_if.m_ready),
        .out_data_o  (buf_out),
        .count_o     (buf_count)
    );

    assign busy_o      = busy;
    assign done_o      = done_q;
    assign ram_addr_o  = ram_addr_q;
    assign m_if.m_valid = buf_valid;
    assign m_if.m_data  = buf_out[DATA_WIDTH-1:0];
    assign m_if.m_last  = buf_valid & buf_out[DATA_WIDTH];

endmodule

// File: doc/dp_ram_stream_reader.md
# dp_ram_stream_reader

Read-side engine for the single-clock dual-port RAM. It takes a start command carrying a base address and a word count, drives the RAM's registered-address read port, and presents the returned words as a valid/ready stream with a last-beat flag. Consumer backpressure is absorbed without losing or duplicating words. It sits between the RAM's read port and any downstream consumer, such as a serializer or a DMA-out path, as the reader counterpart of the block that fills the RAM.

## Interface
- DATA_WIDTH, 8: RAM and stream word width.
- ADDR_WIDTH, 8: RAM address width; RAM depth is 2**ADDR_WIDTH.
- CLK  in  1  single clock for all logic; the RAM read port shares it.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  command strobe; sampled only while BUSY=0.
- START_ADDR  in  ADDR_WIDTH  first RAM address to read.
- LENGTH  in  ADDR_WIDTH+1  word count, 0 to 2**ADDR_WIDTH.
- ABORT  in  1  cancels the current transfer; ignored while idle.
- BUSY  out  1  transfer in progress.
- DONE  out  1  one-cycle pulse when a transfer completes normally.
- RAM_ADDR  out  ADDR_WIDTH  registered read address to the RAM; RAM_DO is valid one cycle later.
- RAM_DO  in  DATA_WIDTH  RAM read data.
- M_DATA  out  DATA_WIDTH  stream data.
- M_VALID  out  1  stream valid.
- M_READY  in  1  stream ready.
- M_LAST  out  1  marks the final beat of a transfer.

## Operation
- States:
  - IDLE: START=1 with LENGTH>0 loads the address and count, then goes to RUN. START with LENGTH=0 stays in IDLE and pulses DONE on the next cycle, with no beats.
  - RUN: issues reads. After the last issue, goes to DRAIN.
  - DRAIN: waits until the final beat handshakes, then returns to IDLE.
- Issue rule: a read issues in a cycle only when (buffer occupancy + reads in flight) < 2, counted after the current cycle's pop.
  - Each issue increments RAM_ADDR modulo 2**ADDR_WIDTH. Wrap from the top address to 0 is legal and continuous.
  - RAM_ADDR holds its value when not issuing.
- Returned data is written into a 2-entry buffer one cycle after its issue. The buffer never overflows, and no word is dropped or repeated.
- Beat order is strictly ascending modulo depth, starting at START_ADDR. Exactly LENGTH beats are produced.
- M_LAST=1 only on beat number LENGTH. M_DATA and M_LAST are stable while M_VALID=1 and M_READY=0.
- START while BUSY=1 is ignored.
- ABORT in RUN or DRAIN:
  - Stops issuing and flushes the buffer and in-flight reads.
  - M_VALID and BUSY go low on the next cycle. No DONE pulse.
  - If ABORT and the final handshake happen in the same cycle, the handshake completes and DONE pulses.
- DONE pulses exactly once per normal completion. BUSY falls in the same cycle that DONE rises.
- Reset values: BUSY=0, DONE=0, RAM_ADDR=0, M_VALID=0, M_LAST=0, M_DATA=0, state IDLE, buffer empty.
  - Reset asserted mid-transfer discards everything immediately.
  - After reset releases, the block waits for a new START.

## Timing
- START is sampled at edge E0. From E0: BUSY=1 and RAM_ADDR=START_ADDR.
- The RAM registers RAM_ADDR at E1. Data is captured at E2, so M_VALID=1 from E2. First-beat latency is 2 cycles.
- With M_READY held high, throughput is 1 beat per cycle with no bubbles.
- A LENGTH=N transfer completes its last handshake at E(N+1). BUSY=0 and DONE=1 follow for one cycle.
- When M_READY drops, issuing stops within one cycle. When M_READY rises, the buffered beats resume with no gap.
- A new START is accepted in the cycle DONE is high, because BUSY=0 at that point.

## Structure
- Shared package dp_ram_pkg holds:
  - the RAM read-latency constant (1);
  - the state encoding (IDLE/RUN/DRAIN);
  - the ADDR_WIDTH/DATA_WIDTH defaults shared with the RAM and its writer.
- One sub-module, stream_skid_buf: a 2-entry valid/ready buffer carrying {last, data}. It exposes its occupancy for the issue rule.
- The top level holds the FSM, address register, remaining-issue counter, in-flight flag and beat counter.

## Test plan
- RAM preloaded with ram[i]=i. START_ADDR=0x10, LENGTH=4, M_READY=1 -> beats 0x10 to 0x13 on consecutive cycles from E2. M_LAST on 0x13. DONE one cycle after.
- START_ADDR=0xFE, LENGTH=4 -> beats 0xFE, 0xFF, 0x00, 0x01. RAM_ADDR wraps to 0.
- LENGTH=8 with M_READY toggling 1,0,0,1,0,1… -> exactly 8 ordered beats, no duplicates. Data held stable while stalled.
- LENGTH=0 -> no M_VALID. DONE pulses once the cycle after START. LENGTH=256 -> 256 beats covering the full RAM.
- ABORT after 3 beats of LENGTH=10 -> M_VALID=0 and BUSY=0 next cycle, no DONE. A subsequent START_ADDR=0x40, LENGTH=2 returns 0x40, 0x41.
- RST_N asserted mid-transfer -> all outputs 0 immediately. Post-reset, START while BUSY=1 of a new transfer is ignored.
